// File: rtl/spi_flash_pkg.sv
// Shared constants, state encoding and helpers for the SPI flash read arbiter.
package spi_flash_pkg;

    localparam logic [7:0]  CMD_READ       = 8'h03;
    localparam int unsigned WORD_BITS      = 32;
    localparam int unsigned XFER_BITS      = 64;
    localparam int unsigned STREAM_TIMEOUT = 16;
    localparam int unsigned ADDR_W         = 24;
    localparam int unsigned BIT_CNT_W      = 7;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_SHIFT_OUT   = 3'd1,
        ST_SHIFT_IN    = 3'd2,
        ST_DONE        = 3'd3,
        ST_CS_HOLD     = 3'd4,
        ST_STREAM_WAIT = 3'd5
    } state_e;

    // Command/address frame for a word-aligned READ.
    function automatic logic [WORD_BITS-1:0] read_frame(input logic [ADDR_W-3:0] word_addr);
        return {CMD_READ, word_addr, 2'b00};
    endfunction

    // Wire order is byte0 first; the returned word is little-endian.
    function automatic logic [WORD_BITS-1:0] byte_swap(input logic [WORD_BITS-1:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/spi_flash_bit_timer.sv
// SPI mode-0 bit timer: divides clk into fsclk half-periods and counts bits.
module spi_flash_bit_timer
    import spi_flash_pkg::*;
#(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [BIT_CNT_W-1:0] nbits,
    output logic                 fsclk,
    output logic [BIT_CNT_W-1:0] bit_idx,
    output logic                 fall_c,
    output logic                 sample_c,
    output logic                 done_c
);

    localparam int unsigned DIV_W = 8;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic                 running;
    logic [DIV_W-1:0]     div_cnt;
    logic [BIT_CNT_W-1:0] nbits_q;
    logic                 phase_end_c;

    // fall_c marks the last cycle of a bit; sample_c the first high cycle.
    always_comb begin
        phase_end_c = running && (div_cnt == DIV_LAST);
        fall_c      = phase_end_c && fsclk;
        sample_c    = running && fsclk && (div_cnt == '0);
        done_c      = fall_c && (bit_idx == BIT_CNT_W'(nbits_q - BIT_CNT_W'(1)));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            running <= 1'b0;
            div_cnt <= '0;
            fsclk   <= 1'b0;
            bit_idx <= '0;
            nbits_q <= '0;
        end else if (start) begin
            running <= 1'b1;
            div_cnt <= '0;
            fsclk   <= 1'b0;
            bit_idx <= '0;
            nbits_q <= nbits;
        end else if (running) begin
            if (phase_end_c) begin
                div_cnt <= '0;
                fsclk   <= ~fsclk;
                if (fsclk) begin
                    if (done_c) begin
                        running <= 1'b0;
                    end else begin
                        bit_idx <= bit_idx + BIT_CNT_W'(1);
                    end
                end
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end
        end
    end

endmodule

// File: rtl/spi_flash_arb_ctrl.sv
// Two-port round-robin SPI flash READ controller (cmd 0x03, 24-bit addr, 32-bit data).
// Optional continuous-read streaming is enabled by defining SPI_FLASH_CONT_READ_EN.
module spi_flash_arb_ctrl
    import spi_flash_pkg::*;
#(
    parameter int unsigned CLK_DIV        = 2,
    parameter int unsigned CS_IDLE_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0_valid,
    input  logic [ADDR_W-1:0]    req0_addr,
    output logic                 req0_ready,
    output logic                 req0_rvalid,
    output logic [WORD_BITS-1:0] req0_rdata,
    input  logic                 req1_valid,
    input  logic [ADDR_W-1:0]    req1_addr,
    output logic                 req1_ready,
    output logic                 req1_rvalid,
    output logic [WORD_BITS-1:0] req1_rdata,
    output logic                 fsclk,
    output logic                 fcen,
    output logic                 mosi,
    input  logic                 miso
);

    localparam int unsigned HOLD_W = 16;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(CS_IDLE_CYCLES - 1);

    state_e                 state;
    logic                   owner;
    logic                   rr_ptr;
    logic [WORD_BITS-1:0]   tx_sr;
    logic [WORD_BITS-1:0]   rx_sr;
    logic [WORD_BITS-1:0]   rx_next_c;
    logic [HOLD_W-1:0]      hold_cnt;
    logic                   grant_c;
    logic                   accept_c;
    logic [ADDR_W-3:0]      acc_word_c;
    logic                   t_start_c;
    logic [BIT_CNT_W-1:0]   t_nbits_c;
    logic [BIT_CNT_W-1:0]   t_bit_idx;
    logic                   t_fall_c;
    logic                   t_sample_c;
    logic                   t_done_c;
    logic                   unused_addr_bits;

`ifdef SPI_FLASH_CONT_READ_EN
    localparam int unsigned STREAM_CNT_W = 5;
    localparam logic [STREAM_CNT_W-1:0] STREAM_LAST = STREAM_CNT_W'(STREAM_TIMEOUT - 1);

    logic [ADDR_W-1:0]       last_addr;
    logic [STREAM_CNT_W-1:0] stream_cnt;
    logic                    own_valid_c;
    logic                    other_valid_c;
    logic                    seq_c;
`endif

    // Byte offset bits are forced to zero and never used.
    assign unused_addr_bits = ^{req0_addr[1:0], req1_addr[1:0]};

    always_comb begin
        grant_c    = (req0_valid && req1_valid) ? rr_ptr : req1_valid;
        accept_c   = (req0_ready && req0_valid) || (req1_ready && req1_valid);
        acc_word_c = owner ? req1_addr[ADDR_W-1:2] : req0_addr[ADDR_W-1:2];
        rx_next_c  = (state == ST_SHIFT_IN && t_sample_c) ? {rx_sr[WORD_BITS-2:0], miso} : rx_sr;
        t_start_c  = accept_c;
`ifdef SPI_FLASH_CONT_READ_EN
        t_nbits_c     = (state == ST_STREAM_WAIT) ? BIT_CNT_W'(WORD_BITS) : BIT_CNT_W'(XFER_BITS);
        own_valid_c   = owner ? req1_valid : req0_valid;
        other_valid_c = owner ? req0_valid : req1_valid;
        seq_c         = own_valid_c &&
                        ({acc_word_c, 2'b00} == ADDR_W'(last_addr + ADDR_W'(4)));
`else
        t_nbits_c     = BIT_CNT_W'(XFER_BITS);
`endif
    end

    spi_flash_bit_timer #(
        .CLK_DIV (CLK_DIV)
    ) u_bit_timer (
        .clk      (clk),
        .rst      (rst),
        .start    (t_start_c),
        .nbits    (t_nbits_c),
        .fsclk    (fsclk),
        .bit_idx  (t_bit_idx),
        .fall_c   (t_fall_c),
        .sample_c (t_sample_c),
        .done_c   (t_done_c)
    );

    // Transaction FSM; ready is raised for one cycle and consumed on the next.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            owner       <= 1'b0;
            rr_ptr      <= 1'b0;
            tx_sr       <= '0;
            rx_sr       <= '0;
            hold_cnt    <= '0;
            fcen        <= 1'b1;
            mosi        <= 1'b0;
            req0_ready  <= 1'b0;
            req1_ready  <= 1'b0;
            req0_rvalid <= 1'b0;
            req1_rvalid <= 1'b0;
            req0_rdata  <= '0;
            req1_rdata  <= '0;
`ifdef SPI_FLASH_CONT_READ_EN
            last_addr   <= '0;
            stream_cnt  <= '0;
`endif
        end else begin
            req0_rvalid <= 1'b0;
            req1_rvalid <= 1'b0;
            rx_sr       <= rx_next_c;
            case (state)
                ST_IDLE: begin
                    if (req0_ready || req1_ready) begin
                        req0_ready <= 1'b0;
                        req1_ready <= 1'b0;
                        if (accept_c) begin
                            state  <= ST_SHIFT_OUT;
                            fcen   <= 1'b0;
                            tx_sr  <= read_frame(acc_word_c);
                            mosi   <= CMD_READ[7];
                            rr_ptr <= ~owner;
`ifdef SPI_FLASH_CONT_READ_EN
                            last_addr <= {acc_word_c, 2'b00};
`endif
                        end
                    end else if (req0_valid || req1_valid) begin
                        owner      <= grant_c;
                        req0_ready <= ~grant_c;
                        req1_ready <= grant_c;
                    end
                end
                ST_SHIFT_OUT: begin
                    if (t_fall_c) begin
                        if (t_bit_idx == BIT_CNT_W'(WORD_BITS - 1)) begin
                            state <= ST_SHIFT_IN;
                            mosi  <= 1'b0;
                        end else begin
                            mosi  <= tx_sr[WORD_BITS-2];
                            tx_sr <= {tx_sr[WORD_BITS-2:0], 1'b0};
                        end
                    end
                end
                ST_SHIFT_IN: begin
                    if (t_done_c) begin
                        state <= ST_DONE;
                        if (owner) begin
                            req1_rvalid <= 1'b1;
                            req1_rdata  <= byte_swap(rx_next_c);
                        end else begin
                            req0_rvalid <= 1'b1;
                            req0_rdata  <= byte_swap(rx_next_c);
                        end
                    end
                end
                ST_DONE: begin
`ifdef SPI_FLASH_CONT_READ_EN
                    state      <= ST_STREAM_WAIT;
                    stream_cnt <= '0;
`else
                    state    <= ST_CS_HOLD;
                    fcen     <= 1'b1;
                    hold_cnt <= '0;
`endif
                end
                ST_CS_HOLD: begin
                    if (hold_cnt == HOLD_LAST) begin
                        state <= ST_IDLE;
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end
`ifdef SPI_FLASH_CONT_READ_EN
                // Chip select stays low; only the next sequential word of the owner continues.
                ST_STREAM_WAIT: begin
                    stream_cnt <= stream_cnt + STREAM_CNT_W'(1);
                    if (req0_ready || req1_ready) begin
                        req0_ready <= 1'b0;
                        req1_ready <= 1'b0;
                        if (accept_c) begin
                            state     <= ST_SHIFT_IN;
                            last_addr <= {acc_word_c, 2'b00};
                            rr_ptr    <= ~owner;
                        end else begin
                            state    <= ST_CS_HOLD;
                            fcen     <= 1'b1;
                            hold_cnt <= '0;
                        end
                    end else if (seq_c) begin
                        req0_ready <= ~owner;
                        req1_ready <= owner;
                    end else if (other_valid_c || own_valid_c || stream_cnt == STREAM_LAST) begin
                        state    <= ST_CS_HOLD;
                        fcen     <= 1'b1;
                        hold_cnt <= '0;
                    end
                end
`endif
                default: begin
                    state <= ST_IDLE;
                    fcen  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_flash_arb_ctrl.sv
// Directed bench for spi_flash_arb_ctrl with a behavioural mode-0 flash model.
module tb_spi_flash_arb_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid;
    logic [23:0] req0_addr, req1_addr;
    logic        req0_ready, req1_ready, req0_rvalid, req1_rvalid;
    logic [31:0] req0_rdata, req1_rdata;
    logic        fsclk, fcen, mosi;
    logic        miso = 1'b0;

    logic        f_req0_valid, f_req1_valid;
    logic [23:0] f_req0_addr, f_req1_addr;
    logic        f_req0_ready, f_req1_ready, f_req0_rvalid, f_req1_rvalid;
    logic [31:0] f_req0_rdata, f_req1_rdata;
    logic        f_fsclk, f_fcen, f_mosi;
    logic        f_miso = 1'b1;

    always #5 clk = ~clk;

    spi_flash_arb_ctrl #(.CLK_DIV(2), .CS_IDLE_CYCLES(2)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_ready(req0_ready),
        .req0_rvalid(req0_rvalid), .req0_rdata(req0_rdata),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_ready(req1_ready),
        .req1_rvalid(req1_rvalid), .req1_rdata(req1_rdata),
        .fsclk(fsclk), .fcen(fcen), .mosi(mosi), .miso(miso)
    );

    spi_flash_arb_ctrl #(.CLK_DIV(1), .CS_IDLE_CYCLES(3)) dut_fast (
        .clk(clk), .rst(rst),
        .req0_valid(f_req0_valid), .req0_addr(f_req0_addr), .req0_ready(f_req0_ready),
        .req0_rvalid(f_req0_rvalid), .req0_rdata(f_req0_rdata),
        .req1_valid(f_req1_valid), .req1_addr(f_req1_addr), .req1_ready(f_req1_ready),
        .req1_rvalid(f_req1_rvalid), .req1_rdata(f_req1_rdata),
        .fsclk(f_fsclk), .fcen(f_fcen), .mosi(f_mosi), .miso(f_miso)
    );

    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Flash model: captures the first 32 mosi bits, returns resp words MSB first.
    int          nrise = 0;
    int          kbit;
    logic [31:0] cap = '0;
    logic [31:0] seen_frame = '0;
    logic [31:0] resp [0:1];
    logic [31:0] wsel;

    always @(posedge fcen) nrise = 0;
    always @(posedge fsclk) begin
        if (!fcen) begin
            cap   = {cap[30:0], mosi};
            nrise = nrise + 1;
            if (nrise == 32) seen_frame = cap;
        end
    end
    always @(negedge fsclk) begin
        if (!fcen && nrise >= 32) begin
            kbit = nrise - 32;
            wsel = resp[(kbit / 32) % 2];
            miso = wsel[31 - (kbit % 32)];
        end
    end

    int   rv0_cnt = 0;
    logic mon_en = 1'b0;
    int   fcen_hi = 0;
    always @(negedge clk) begin
        if (req0_rvalid) rv0_cnt <= rv0_cnt + 1;
        if (mon_en && fcen) fcen_hi <= fcen_hi + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Presents a request and returns the acceptance cycle; ends at the negedge of T+1.
    task automatic req_acc(input int p, input logic [23:0] a, output int t_acc);
        int n = 0;
        t_acc = -1;
        if (p == 0) begin req0_addr = a; req0_valid = 1'b1; end
        else        begin req1_addr = a; req1_valid = 1'b1; end
        while (n < 100) begin
            if ((p == 0 && req0_ready) || (p == 1 && req1_ready)) begin
                t_acc = cyc;
                break;
            end
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        if (p == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
        check("accept_timeout", 32'(t_acc < 0), 32'd0);
    endtask

    task automatic wait_rv(input int p, output int t_rv, output logic [31:0] data);
        int n = 0;
        t_rv = -1;
        data = '0;
        while (n < 600) begin
            if ((p == 0 && req0_rvalid) || (p == 1 && req1_rvalid)) begin
                t_rv = cyc;
                data = (p == 0) ? req0_rdata : req1_rdata;
                break;
            end
            @(negedge clk);
            n++;
        end
        check("rvalid_timeout", 32'(t_rv < 0), 32'd0);
    endtask

    int          ta, tr, ta2, tr2, n, k, hi, rv_base;
    int          order [4];
    int          tacc [4];
    logic [31:0] d;
    logic [3:0]  fs;

    initial begin
        rst = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0; req0_addr = '0; req1_addr = '0;
        f_req0_valid = 1'b0; f_req1_valid = 1'b0; f_req0_addr = '0; f_req1_addr = '0;
        resp[0] = 32'h11223344;
        resp[1] = 32'h0;
        repeat (3) @(negedge clk);
        check("rst_fcen", 32'(fcen), 32'd1);
        check("rst_fsclk", 32'(fsclk), 32'd0);
        check("rst_mosi", 32'(mosi), 32'd0);
        check("rst_ready", 32'({req0_ready, req1_ready}), 32'd0);
        check("rst_rvalid", 32'({req0_rvalid, req1_rvalid}), 32'd0);
        check("rst_rdata", req0_rdata | req1_rdata, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Port 0 basic read
        req_acc(0, 24'h000100, ta);
        check("p0_fcen_fall", 32'(fcen), 32'd0);
        wait_rv(0, tr, d);
        check("p0_latency", 32'(tr - ta), 32'd257);
        check("p0_rdata", d, 32'h44332211);
        check("p0_frame", seen_frame, 32'h03000100);
        @(negedge clk);
        check("p0_rvalid_pulse", 32'(req0_rvalid), 32'd0);
        check("p0_rdata_hold", req0_rdata, 32'h44332211);

        // Port 1 with unaligned address
        resp[0] = 32'hA1B2C3D4;
        req_acc(1, 24'h000103, ta);
        wait_rv(1, tr, d);
        check("p1_frame", seen_frame, 32'h03000100);
        check("p1_rdata", d, 32'hD4C3B2A1);
        check("p1_latency", 32'(tr - ta), 32'd257);

        // Both ports held valid from reset: grants alternate starting at port 0
        rst = 1'b1;
        req0_addr = 24'h000010; req1_addr = 24'h000020;
        req0_valid = 1'b1; req1_valid = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        k = 0; n = 0;
        while (k < 4 && n < 3000) begin
            if (req0_ready && req0_valid) begin order[k] = 0; tacc[k] = cyc; k++; end
            else if (req1_ready && req1_valid) begin order[k] = 1; tacc[k] = cyc; k++; end
            @(negedge clk);
            n++;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        check("rr_grant_count", 32'(k), 32'd4);
        for (int i = 0; i < 4; i++) check("rr_grant_order", 32'(order[i]), 32'(i % 2));
        check("rr_min_gap", 32'((tacc[1] - tacc[0]) >= 260), 32'd1);

        // Reset during data bit 10, then a clean read
        do_reset();
        resp[0] = 32'h11223344;
        req_acc(0, 24'h000100, ta);
        while (cyc < ta + 169) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_fcen", 32'(fcen), 32'd1);
        check("mid_rst_fsclk", 32'(fsclk), 32'd0);
        check("mid_rst_rvalid", 32'(req0_rvalid), 32'd0);
        rst = 1'b0;
        rv_base = rv0_cnt;
        repeat (300) @(negedge clk);
        check("mid_rst_no_rvalid", 32'(rv0_cnt - rv_base), 32'd0);
        resp[0] = 32'h55667788;
        req_acc(0, 24'h000400, ta);
        wait_rv(0, tr, d);
        check("post_rst_rdata", d, 32'h88776655);
        check("post_rst_latency", 32'(tr - ta), 32'd257);

        // CLK_DIV=1, CS_IDLE_CYCLES=3 instance, miso tied high
        f_req0_addr = 24'h000010;
        f_req0_valid = 1'b1;
        ta = -1; n = 0;
        while (n < 100) begin
            if (f_req0_ready) begin ta = cyc; break; end
            @(negedge clk);
            n++;
        end
        check("fast_accept_timeout", 32'(ta < 0), 32'd0);
        fs = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            fs = {fs[2:0], f_fsclk};
            if (i == 0) check("fast_fcen_fall", 32'(f_fcen), 32'd0);
        end
        check("fast_fsclk_pattern", 32'(fs), 32'h5);
        tr = -1; n = 0;
        while (n < 300) begin
            if (f_req0_rvalid) begin tr = cyc; d = f_req0_rdata; break; end
            @(negedge clk);
            n++;
        end
        check("fast_latency", 32'(tr - ta), 32'd129);
        check("fast_rdata", d, 32'hFFFFFFFF);
        n = 0;
        while (n < 40 && !f_fcen) begin @(negedge clk); n++; end
        hi = 0; n = 0;
        while (n < 100 && f_fcen) begin hi++; @(negedge clk); n++; end
        f_req0_valid = 1'b0;
        check("fast_cs_idle_min", 32'(hi >= 3), 32'd1);
        check("fast_second_start", 32'(f_fcen), 32'd0);

`ifdef SPI_FLASH_CONT_READ_EN
        // Sequential stream: fcen stays low across both words
        do_reset();
        resp[0] = 32'h01020304;
        resp[1] = 32'h05060708;
        req_acc(0, 24'h000200, ta);
        fcen_hi = 0;
        mon_en = 1'b1;
        wait_rv(0, tr, d);
        check("stream_first_latency", 32'(tr - ta), 32'd257);
        check("stream_first_rdata", d, 32'h04030201);
        req_acc(0, 24'h000204, ta2);
        wait_rv(0, tr2, d);
        check("stream_second_latency", 32'(tr2 - ta2), 32'd129);
        check("stream_second_rdata", d, 32'h08070605);
        @(negedge clk);
        mon_en = 1'b0;
        @(negedge clk);
        check("stream_fcen_low", 32'(fcen_hi), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
